stim_player: RTL and testbench
==============================

STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 Parameter DEPTH, default 8: entry buffer depth, power of two, >= 2.
REQ-002 Parameter VW, default 2: width of the played value.
REQ-003 Parameter TW, default 8: width of the per-entry delay field.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr_valid  input  1  entry write request.
REQ-007 wr_ready  output  1  buffer can accept an entry this cycle.
REQ-008 wr_delay  input  TW  idle cycles before the entry's value is applied.
REQ-009 wr_value  input  VW  value to drive when the entry fires.
REQ-010 start  input  1  begin playback; one-cycle pulse.
REQ-011 stop  input  1  abort playback; one-cycle pulse.
REQ-012 out_value  output  VW  registered played value, held between entries.
REQ-013 out_strobe  output  1  one-cycle pulse: out_value changed this cycle.
REQ-014 busy  output  1  playback in progress.
REQ-015 done  output  1  one-cycle pulse with the last entry's strobe.
REQ-016 count  output  clog2(DEPTH)+1  entries currently buffered.

Function
REQ-017 The buffer SHALL be a FIFO of {delay,value} entries; push when wr_valid && wr_ready; wr_ready = (count != DEPTH).
REQ-018 States SHALL be IDLE and PLAY; a timer register of width TW tracks the head entry.
REQ-019 IDLE: start && count != 0 -> PLAY, timer <= head delay; start with count == 0 ignored, no done.
REQ-020 PLAY, timer != 0: timer decrements by one.
REQ-021 PLAY, timer == 0: out_value <= head value, out_strobe <= 1, head popped; timer <= next head delay if another entry remains, else state -> IDLE and done <= 1 in the same cycle as the strobe.
REQ-022 Latency: start sampled at edge N with head delay d -> strobe visible after edge N+d+1; each later entry strobes delay+1 cycles after the previous strobe.
REQ-023 start while busy SHALL be ignored.
REQ-024 stop in PLAY -> IDLE next edge, no strobe, no done, remaining entries retained, out_value held; stop wins over a same-cycle fire; stop in IDLE ignored.
REQ-025 Pushes during PLAY are allowed; an entry pushed in the cycle the last entry pops SHALL NOT be played; playback ends and the entry stays buffered.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 busy = (state == PLAY).

Reset
REQ-028 rst SHALL clear state to IDLE, pointers and count to 0, timer to 0, out_value to 0, out_strobe, done, busy to 0; wr_ready is 1 out of reset.
REQ-029 rst mid-playback SHALL discard all buffered entries; no strobe or done is emitted.

Configuration
REQ-030 Macro STIM_PLAYER_LOOP_EN, when defined, SHALL add input loop (1 bit); with loop high at the pop, the popped entry is re-pushed at the tail, playback never ends by itself (stop required), done never pulses, and wr_ready is 0 in PLAY.
REQ-031 Without STIM_PLAYER_LOOP_EN, no loop port exists and behaviour is exactly REQ-017..REQ-027.

Structure
REQ-032 A shared package stim_pkg SHALL hold the state encodings, default DEPTH/VW/TW and the entry field layout.
REQ-033 The FIFO SHALL be a sub-module stim_fifo (push, pop, head, count, full, empty); stim_player holds the FSM, timer and output registers.

Verification
REQ-034 Entries (0,01),(1,10); start at edge 0 -> strobe with out_value 01 after edge 1, 10 after edge 3, done with second strobe, busy low after edge 3.
REQ-035 start with empty buffer -> no strobe, no done, busy stays 0.
REQ-036 Push 8 entries -> wr_ready 0, count 8; 9th write not accepted; start then one pop -> wr_ready 1.
REQ-037 Entries (5,11),(5,01); stop two cycles after start -> no strobe, IDLE, count 2, out_value 0; restart plays 11 after 6 cycles.
REQ-038 rst asserted during PLAY with 3 entries buffered -> count 0, out_value 0, busy 0, no done.
REQ-039 With STIM_PLAYER_LOOP_EN and loop=1, entries (0,01),(0,10) -> strobes alternate 01,10 every cycle until stop; done never asserts.

Source files
------------

// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stim_pkg
//  Purpose  : Shared definitions for the stimulus player: default geometry,
//             FSM state encodings and the layout of a buffered entry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package stim_pkg;

    // Default geometry
    localparam int STIM_DEPTH_DEFAULT = 8;
    localparam int STIM_VW_DEFAULT    = 2;
    localparam int STIM_TW_DEFAULT    = 8;

    // Player FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // Entry layout is {delay, value}: value occupies the low VW bits and the
    // delay field sits directly above it in the top TW bits.
    localparam int ENTRY_VALUE_LSB = 0;

    function automatic int entry_width(input int vw, input int tw);
        return vw + tw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stim_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stim_fifo
//  Purpose  : Entry FIFO for the stimulus player. Also exposes the delay
//             field of the entry behind the head, so the player can reload
//             its timer in the same cycle that it pops the head.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             push, push_data   - write one entry (caller guarantees room,
//                                 or a simultaneous pop)
//             pop               - discard the head entry (caller guarantees
//                                 the FIFO is not empty)
//             head              - entry at the read pointer
//             next_delay        - delay field of the entry after the head
//             count, full, empty- occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module stim_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    parameter int TW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [TW-1:0]            next_delay,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [AW-1:0] w_rd_next;

    // DEPTH is a power of two, so plain pointer increments wrap correctly.
    assign w_rd_next = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = w_rd_next;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign next_delay = mem_q[w_rd_next][W-1 -: TW];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/stim_player.sv
`default_nettype none
// ============================================================================
//  Module   : stim_player
//  Purpose  : Plays back buffered {delay, value} entries: each entry waits
//             'delay' idle cycles, then drives its value on out_value with a
//             one-cycle out_strobe. done pulses with the final strobe.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             wr_valid/wr_ready/wr_delay/wr_value - entry write interface
//             start, stop                    - playback control pulses
//             out_value, out_strobe          - played value and change pulse
//             busy, done, count              - status
//             loop (STIM_PLAYER_LOOP_EN only) - re-queue each popped entry
//  Config   : define STIM_PLAYER_LOOP_EN to add the loop input.
//  Revision : 1.0 - initial release
// ============================================================================
module stim_player
    import stim_pkg::*;
#(
    parameter int DEPTH = STIM_DEPTH_DEFAULT,
    parameter int VW    = STIM_VW_DEFAULT,
    parameter int TW    = STIM_TW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [TW-1:0]          wr_delay,
    input  logic [VW-1:0]          wr_value,
    input  logic                   start,
    input  logic                   stop,
`ifdef STIM_PLAYER_LOOP_EN
    input  logic                   loop,
`endif
    output logic [VW-1:0]          out_value,
    output logic                   out_strobe,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int EW = entry_width(VW, TW);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]    state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [VW-1:0] out_value_q, out_value_d;
    logic          strobe_q,    strobe_d;
    logic          done_q,      done_d;

    logic [EW-1:0] w_head;
    logic [EW-1:0] w_push_data;
    logic [TW-1:0] w_next_delay;
    logic [TW-1:0] w_head_delay;
    logic [VW-1:0] w_head_value;
    logic [TW-1:0] w_reload;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_loop;
    logic          w_fire;
    logic          w_more;
    logic          w_ext_push;
    logic          w_repush;
    logic          w_push;

`ifdef STIM_PLAYER_LOOP_EN
    assign w_loop   = loop;
    // External writes would race with the re-push of popped entries.
    assign wr_ready = !w_full && (state_q != ST_PLAY);
`else
    assign w_loop   = 1'b0;
    assign wr_ready = !w_full;
`endif

    assign w_head_delay = w_head[EW-1 -: TW];
    assign w_head_value = w_head[ENTRY_VALUE_LSB +: VW];

    // stop overrides a fire in the same cycle.
    assign w_fire = (state_q == ST_PLAY) && !stop && (timer_q == '0);

    // Decided on the pre-push count, so an entry written in the cycle the
    // last entry pops is left buffered rather than played.
    assign w_more = w_loop || (w_count > CW'(1));

    // With a single looping entry the head re-enters as its own successor.
    assign w_reload = (w_count > CW'(1)) ? w_next_delay : w_head_delay;

    assign w_ext_push  = wr_valid && wr_ready;
    assign w_repush    = w_fire && w_loop;
    assign w_push      = w_ext_push || w_repush;
    assign w_push_data = w_repush ? w_head : {wr_delay, wr_value};

    stim_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .TW    (TW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (w_fire),
        .head       (w_head),
        .next_delay (w_next_delay),
        .count      (w_count),
        .full       (w_full),
        .empty      (w_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            out_value_q <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            out_value_q <= out_value_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !w_empty) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (w_fire && !w_more) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer and registered outputs
    always_comb begin
        timer_d     = timer_q;
        out_value_d = out_value_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !w_empty) begin
                    timer_d = w_head_delay;
                end
            end
            ST_PLAY: begin
                if (!stop) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        out_value_d = w_head_value;
                        strobe_d    = 1'b1;
                        if (w_more) begin
                            timer_d = w_reload;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
    end

    assign out_value  = out_value_q;
    assign out_strobe = strobe_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_PLAY);
    assign count      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_stim_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stim_player
//  Purpose  : Self-checking bench for stim_player. A queue-based reference
//             model schedules each strobe at an absolute cycle number and is
//             compared against every DUT output after every clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stim_player;

    localparam int DEPTH = 8;
    localparam int VW    = 2;
    localparam int TW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STIM_PLAYER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [TW-1:0] wr_delay;
    logic [VW-1:0] wr_value;
    logic          start;
    logic          stop;
    logic          loop_in;
    logic [VW-1:0] out_value;
    logic          out_strobe;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    stim_player #(
        .DEPTH (DEPTH),
        .VW    (VW),
        .TW    (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_delay   (wr_delay),
        .wr_value   (wr_value),
        .start      (start),
        .stop       (stop),
`ifdef STIM_PLAYER_LOOP_EN
        .loop       (loop_in),
`endif
        .out_value  (out_value),
        .out_strobe (out_strobe),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: buffered entries in a queue; while playing, the
    // absolute cycle at which the head fires.
    typedef struct { int d; int v; } ent_t;
    ent_t q[$];
    bit   m_play   = 1'b0;
    int   m_fire   = 0;
    int   m_val    = 0;
    bit   m_strobe = 1'b0;
    bit   m_done   = 1'b0;
    int   k        = 0;

    task automatic model_step(input bit wv, input int d, input int v,
                              input bit st, input bit sp, input bit r, input bit lp);
        int   pre;
        bit   acc;
        ent_t e;
        m_strobe = 1'b0;
        m_done   = 1'b0;
        if (r) begin
            q.delete();
            m_play = 1'b0;
            m_val  = 0;
        end else begin
            pre = q.size();
            acc = wv && (pre != DEPTH) && !(LOOP_EN && m_play);
            if (m_play) begin
                if (sp) begin
                    m_play = 1'b0;
                end else if (k == m_fire) begin
                    e = q.pop_front();
                    m_val    = e.v;
                    m_strobe = 1'b1;
                    if (LOOP_EN && lp) q.push_back(e);
                    if (q.size() != 0) begin
                        m_fire = k + q[0].d + 1;
                    end else begin
                        m_play = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (st && pre != 0) begin
                m_play = 1'b1;
                m_fire = k + q[0].d + 1;
            end
            if (acc) q.push_back('{d, v});
        end
        k++;
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it.
    task automatic cycle(input bit wv, input int d, input int v,
                         input bit st, input bit sp, input bit r);
        bit lp;
        lp       = loop_in;
        wr_valid = wv;
        wr_delay = d[TW-1:0];
        wr_value = v[VW-1:0];
        start    = st;
        stop     = sp;
        rst      = r;
        @(posedge clk);
        model_step(wv, d, v, st, sp, r, lp);
        #1;
        check("strobe",   {31'd0, out_strobe}, {31'd0, m_strobe});
        check("value",    32'(out_value), 32'(m_val));
        check("done",     {31'd0, done}, {31'd0, m_done});
        check("busy",     {31'd0, busy}, {31'd0, m_play});
        check("count",    32'(count), 32'(q.size()));
        check("wr_ready", {31'd0, wr_ready},
              {31'd0, (q.size() != DEPTH) && !(LOOP_EN && m_play)});
        wr_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_delay = '0; wr_value = '0;
        start = 1'b0; stop = 1'b0; loop_in = 1'b0;

        // Reset state
        do_reset();
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_value", 32'(out_value), 32'd0);

        // Two-entry playback with fixed latency
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 2, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("p1_strobe", {31'd0, out_strobe}, 32'd1);
        check("p1_value",  32'(out_value), 32'd1);
        idle(2);
        check("p2_strobe", {31'd0, out_strobe}, 32'd1);
        check("p2_value",  32'(out_value), 32'd2);
        check("p2_done",   {31'd0, done}, 32'd1);
        check("p2_busy",   {31'd0, busy}, 32'd0);
        idle(2);

        // Start with empty buffer
        do_reset();
        cycle(0, 0, 0, 1, 0, 0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        idle(3);

        // Fill to capacity, overfill, then one pop frees a slot
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, i % 4, 0, 0, 0);
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_ready", {31'd0, wr_ready}, 32'd0);
        cycle(1, 0, 3, 0, 0, 0);
        check("ovf_count", 32'(count), 32'(DEPTH));
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("pop_ready", {31'd0, wr_ready}, 32'd1);
        idle(DEPTH + 2);

        // Stop retains entries; restart plays the head after delay+1
        do_reset();
        cycle(1, 5, 3, 0, 0, 0);
        cycle(1, 5, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("stop_busy",  {31'd0, busy}, 32'd0);
        check("stop_count", 32'(count), 32'd2);
        check("stop_value", 32'(out_value), 32'd0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(6);
        check("restart_strobe", {31'd0, out_strobe}, 32'd1);
        check("restart_value",  32'(out_value), 32'd3);
        idle(8);

        // Reset during playback
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 3, i + 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1);
        check("rstp_count", 32'(count), 32'd0);
        check("rstp_busy",  {31'd0, busy}, 32'd0);
        check("rstp_done",  {31'd0, done}, 32'd0);
        idle(5);

`ifdef STIM_PLAYER_LOOP_EN
        // Looping playback alternates until stopped
        do_reset();
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 2, 0, 0, 0);
        loop_in = 1'b1;
        cycle(0, 0, 0, 1, 0, 0);
        idle(7);
        cycle(0, 0, 0, 0, 1, 0);
        loop_in = 1'b0;
        idle(2);
`endif

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (LOOP_EN) loop_in = ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 249) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
